// File: rtl/down_counter_pkg.sv
// Shared state encoding and width bounds for the loadable down-counter timer.
package down_counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/down_counter_core.sv
// Count register: sync clear, load, decrement; zero flag is combinational.
// Single-cycle update; enables come from the owning FSM, no backpressure.
module down_counter_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic [WIDTH-1:0] out,
   output logic             zero
);

   always_ff @(posedge clk) begin
      if (reset) begin
         out <= '0;
      end else if (load) begin
         out <= load_val;
      end else if (dec) begin
         out <= out - WIDTH'(1);
      end
   end

   assign zero = (out == '0);

endmodule

// File: rtl/down_counter_timer.sv
// Start/done interval timer: load on start, count down on dec, one-cycle done at zero.
// Start-to-done is N+1 cycles with dec held high; abort or reset cancels without done.
module down_counter_timer
   import down_counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   input  logic             abort,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   state_t state;
   logic   load_en;
   logic   dec_en;
   logic   last_dec;

   // DONE accepts start like IDLE so back-to-back counts have no gap.
   assign load_en  = start && (state == ST_IDLE || state == ST_DONE);
   assign dec_en   = (state == ST_RUN) && !abort && dec;
   assign last_dec = (out == WIDTH'(1));

   down_counter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .reset    (reset),
      .load     (load_en),
      .load_val (load_val),
      .dec      (dec_en),
      .out      (out),
      .zero     (zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  if (load_val != '0) begin
                     state <= ST_RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end else begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end else if (dec && last_dec) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed checks of down_counter_timer (WIDTH=4): reset, counting, dec gaps,
// zero load, abort, and back-to-back reload from DONE.
module tb_down_counter_timer;

   localparam int WIDTH = 4;

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] load_val;
   logic             dec;
   logic             abort;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;
   logic             zero;

   int checks = 0;
   int errors = 0;

   down_counter_timer #(
      .WIDTH (WIDTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .load_val (load_val),
      .dec      (dec),
      .abort    (abort),
      .out      (out),
      .busy     (busy),
      .done     (done),
      .zero     (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [WIDTH-1:0] e_out,
                            input logic e_busy, input logic e_done);
      check({tag, ".out"},  16'(out),  16'(e_out));
      check({tag, ".busy"}, 16'(busy), 16'(e_busy));
      check({tag, ".done"}, 16'(done), 16'(e_done));
      check({tag, ".zero"}, 16'(zero), 16'(e_out == '0));
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      load_val = '0;
      dec      = 1'b0;
      abort    = 1'b0;
      tick();
      tick();
      check_all("reset_init", 4'd0, 1'b0, 1'b0);

      // 1: reset during RUN at out=7
      reset = 1'b0;
      start = 1'b1; load_val = 4'd7;
      tick();
      start = 1'b0;
      check_all("t1_load", 4'd7, 1'b1, 1'b0);
      tick();
      check_all("t1_hold", 4'd7, 1'b1, 1'b0);
      reset = 1'b1;
      tick();
      tick();
      check_all("t1_reset", 4'd0, 1'b0, 1'b0);
      reset = 1'b0;
      dec   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("t1_after", 4'd0, 1'b0, 1'b0);
      end

      // 2: load 5, dec held high
      start = 1'b1; load_val = 4'd5;
      tick();
      start = 1'b0;
      check_all("t2_load", 4'd5, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check_all($sformatf("t2_step%0d", i), 4'(5 - i), i < 5, i == 5);
      end
      tick();
      check_all("t2_idle", 4'd0, 1'b0, 1'b0);

      // 3: load 3, dec pattern 1,0,0,1,1
      dec   = 1'b0;
      start = 1'b1; load_val = 4'd3;
      tick();
      start = 1'b0;
      check_all("t3_load", 4'd3, 1'b1, 1'b0);
      dec = 1'b1; tick(); check_all("t3_d1", 4'd2, 1'b1, 1'b0);
      dec = 1'b0; tick(); check_all("t3_d2", 4'd2, 1'b1, 1'b0);
      dec = 1'b0; tick(); check_all("t3_d3", 4'd2, 1'b1, 1'b0);
      dec = 1'b1; tick(); check_all("t3_d4", 4'd1, 1'b1, 1'b0);
      dec = 1'b1; tick(); check_all("t3_d5", 4'd0, 1'b0, 1'b1);
      dec = 1'b0; tick(); check_all("t3_idle", 4'd0, 1'b0, 1'b0);

      // 4: zero load goes straight to DONE
      start = 1'b1; load_val = 4'd0;
      tick();
      start = 1'b0;
      check_all("t4_done", 4'd0, 1'b0, 1'b1);
      tick();
      check_all("t4_idle", 4'd0, 1'b0, 1'b0);

      // 5: abort beats dec at out=4, then a fresh count of 2
      dec   = 1'b1;
      start = 1'b1; load_val = 4'd6;
      tick();
      start = 1'b0;
      check_all("t5_load", 4'd6, 1'b1, 1'b0);
      tick(); check_all("t5_c5", 4'd5, 1'b1, 1'b0);
      tick(); check_all("t5_c4", 4'd4, 1'b1, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_all("t5_abort", 4'd4, 1'b0, 1'b0);
      tick();
      check_all("t5_idle_dec", 4'd4, 1'b0, 1'b0);
      start = 1'b1; load_val = 4'd2;
      tick();
      start = 1'b0;
      check_all("t5_reload", 4'd2, 1'b1, 1'b0);
      tick(); check_all("t5_r1", 4'd1, 1'b1, 1'b0);
      tick(); check_all("t5_r0", 4'd0, 1'b0, 1'b1);

      // 6: start during DONE reloads max value; start mid-RUN ignored
      start = 1'b1; load_val = 4'd15;
      tick();
      check_all("t6_b2b", 4'd15, 1'b1, 1'b0);
      load_val = 4'd3; dec = 1'b0;
      tick();
      check_all("t6_ign", 4'd15, 1'b1, 1'b0);
      start = 1'b0; dec = 1'b1;
      tick();
      check_all("t6_dec", 4'd14, 1'b1, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_all("t6_abort", 4'd14, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
